// File: rtl/spike_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spike_filter_ctrl
// Purpose  : Controller in front of the spike filter array.
//            - Periodic timer generating the array's one-cycle update_pulse.
//            - Tracks the decay sweep after each pulse by counting the
//              array's output handshakes; flags overruns (period too short
//              for a sweep) and out-of-order output indices.
//            - Round-robin arbiter merging two tag/count requesters onto the
//              array's single input through a one-deep output register.
// Ports    : clk, reset (async, active-high)
//            conf_period / conf_filts_used / clear_err   configuration
//            a_* / b_*                                    requesters A and B
//            arr_v / arr_tag / arr_ct / arr_a             array input
//            arr_out_v / arr_out_a / arr_out_idx          monitored array output
//            update_pulse, busy, overrun, overrun_ct, seq_err   status
// Revision : 1.0 - initial release
// ============================================================================
module spike_filter_ctrl #(
  parameter int Nfilts  = 10,
  parameter int Nct     = 10,
  parameter int Nperiod = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Nperiod-1:0] conf_period,
  input  logic [Nfilts-1:0]  conf_filts_used,
  input  logic               clear_err,
  input  logic               a_v,
  input  logic [Nfilts-1:0]  a_tag,
  input  logic [Nct-1:0]     a_ct,
  output logic               a_a,
  input  logic               b_v,
  input  logic [Nfilts-1:0]  b_tag,
  input  logic [Nct-1:0]     b_ct,
  output logic               b_a,
  output logic               arr_v,
  output logic [Nfilts-1:0]  arr_tag,
  output logic [Nct-1:0]     arr_ct,
  input  logic               arr_a,
  input  logic               arr_out_v,
  input  logic               arr_out_a,
  input  logic [Nfilts-1:0]  arr_out_idx,
  output logic               update_pulse,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         overrun_ct,
  output logic               seq_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Period timer. The compare is done one bit wider so that cnt+1 cannot wrap.
  // --------------------------------------------------------------------------
  logic [Nperiod-1:0] cnt_q;
  logic [Nperiod:0]   cnt_inc;
  logic               expiry;

  assign cnt_inc = {1'b0, cnt_q} + {{Nperiod{1'b0}}, 1'b1};
  // ">=" rather than "==" so lowering conf_period mid-count expires at once.
  assign expiry  = (conf_period != '0) && (cnt_inc >= {1'b0, conf_period});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (expiry || (conf_period == '0)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc[Nperiod-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Sweep tracker and error flags
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [Nfilts-1:0] n_q;        // filter count latched at the pulse
  logic [Nfilts-1:0] swcnt_q;    // handshakes seen in this sweep
  logic [Nfilts-1:0] last_idx;
  logic              update_pulse_q;
  logic              busy_q;
  logic              overrun_q;
  logic [7:0]        overrun_ct_q;
  logic [7:0]        overrun_ct_d;
  logic              seq_err_q;
  logic              out_hs;
  logic              ov_ev;
  logic              seq_ev;

  assign out_hs   = arr_out_v & arr_out_a;
  assign last_idx = n_q - {{(Nfilts-1){1'b0}}, 1'b1};
  assign ov_ev    = expiry & (state_q == SWEEP);
  assign seq_ev   = (state_q == SWEEP) & out_hs & (arr_out_idx != swcnt_q);

  // Clear is applied first so that an overrun in the same cycle yields 1.
  always_comb begin
    overrun_ct_d = clear_err ? 8'd0 : overrun_ct_q;
    if (ov_ev && (overrun_ct_d != 8'hFF)) begin
      overrun_ct_d = overrun_ct_d + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      n_q            <= '0;
      swcnt_q        <= '0;
      update_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      overrun_ct_q   <= 8'd0;
      seq_err_q      <= 1'b0;
    end else begin
      update_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // An expiry with no active filters is simply skipped.
          if (expiry && (conf_filts_used != '0)) begin
            update_pulse_q <= 1'b1;
            n_q            <= conf_filts_used;
            swcnt_q        <= '0;
            busy_q         <= 1'b1;
            state_q        <= SWEEP;
          end
        end
        SWEEP: begin
          if (out_hs) begin
            swcnt_q <= swcnt_q + 1'b1;
            if (swcnt_q == last_idx) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      overrun_q    <= ov_ev | (overrun_q & ~clear_err);
      overrun_ct_q <= overrun_ct_d;
      seq_err_q    <= seq_ev | (seq_err_q & ~clear_err);
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter with one-deep output register
  // --------------------------------------------------------------------------
  logic              arr_v_q;
  logic [Nfilts-1:0] arr_tag_q;
  logic [Nct-1:0]    arr_ct_q;
  logic              last_grant_q;   // 0 = A, 1 = B
  logic              load;
  logic              grant_a;
  logic              grant_b;

  // The register may take new data when empty or when being drained now.
  assign load = ~arr_v_q | arr_a;

  always_comb begin
    grant_a = load & a_v & (~b_v | last_grant_q);
    grant_b = load & b_v & (~a_v | ~last_grant_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arr_v_q      <= 1'b0;
      arr_tag_q    <= '0;
      arr_ct_q     <= '0;
      last_grant_q <= 1'b1;
    end else if (load) begin
      if (grant_a) begin
        arr_v_q      <= 1'b1;
        arr_tag_q    <= a_tag;
        arr_ct_q     <= a_ct;
        last_grant_q <= 1'b0;
      end else if (grant_b) begin
        arr_v_q      <= 1'b1;
        arr_tag_q    <= b_tag;
        arr_ct_q     <= b_ct;
        last_grant_q <= 1'b1;
      end else begin
        arr_v_q <= 1'b0;
      end
    end
  end

  assign a_a          = grant_a;
  assign b_a          = grant_b;
  assign arr_v        = arr_v_q;
  assign arr_tag      = arr_tag_q;
  assign arr_ct       = arr_ct_q;
  assign update_pulse = update_pulse_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign overrun_ct   = overrun_ct_q;
  assign seq_err      = seq_err_q;

endmodule
`default_nettype wire
